// File: rtl/apple_placement_if.sv
// rtl/apple_placement_if.sv - handshake/bus bundle between game logic and the apple placement controller
interface apple_placement_if #(
  parameter int MAX_LENGTH = 16,
  parameter int LW         = $clog2(MAX_LENGTH + 1)
);
  logic                    goodColl;
  logic [3:0]              randX;
  logic [3:0]              randY;
  logic [8*MAX_LENGTH-1:0] body;
  logic [LW-1:0]           length;
  logic [3:0]              apple_x;
  logic [3:0]              apple_y;
  logic                    apple_valid;
  logic                    busy;
  logic                    place_done;
  logic                    board_full;

  // Game side: raises goodColl, supplies randomness and the body list
  modport master (
    output goodColl, randX, randY, body, length,
    input  apple_x, apple_y, apple_valid, busy, place_done, board_full
  );

  // Controller side
  modport slave (
    input  goodColl, randX, randY, body, length,
    output apple_x, apple_y, apple_valid, busy, place_done, board_full
  );
endinterface

// File: rtl/apple_placement_ctrl.sv
// rtl/apple_placement_ctrl.sv - draws, checks and commits a new apple position after the snake eats one
module apple_placement_ctrl #(
  parameter int MAX_LENGTH = 16,
  parameter int MAX_TRIES  = 4,
  parameter int LW         = $clog2(MAX_LENGTH + 1)
) (
  input logic              clk,
  input logic              reset,
  apple_placement_if.slave bus
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int IW = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, CHECK, COMMIT} state_t;

  state_t        state;
  logic          gc_q;
  logic          rise_q;
  logic [7:0]    cand;
  logic [TW-1:0] tries;
  logic          scan;
  logic [8:0]    scanned;
  logic [IW-1:0] idx;
  logic [3:0]    apple_x_r;
  logic [3:0]    apple_y_r;
  logic          apple_valid_r;
  logic          busy_r;
  logic          place_done_r;
  logic          board_full_r;

  logic [7:0]    segs [MAX_LENGTH];
  logic [7:0]    seg;
  logic          rise;
  logic          hit;
  logic          last;

  // Unpack the flattened body list so the current segment is a plain array read
  always_comb begin
    for (int i = 0; i < MAX_LENGTH; i++) begin
      segs[i] = bus.body[8*i +: 8];
    end
  end

  assign seg  = segs[idx];
  assign rise = bus.goodColl & ~gc_q;
  // An empty body never overlaps; the single CHECK cycle then goes straight to COMMIT
  assign hit  = (bus.length != '0) && (cand == seg);
  assign last = (bus.length == '0) || (LW'(idx) == bus.length - LW'(1));

  assign bus.apple_x     = apple_x_r;
  assign bus.apple_y     = apple_y_r;
  assign bus.apple_valid = apple_valid_r;
  assign bus.busy        = busy_r;
  assign bus.place_done  = place_done_r;
  assign bus.board_full  = board_full_r;

  // Placement sequencer; the edge is captured into rise_q and acted on the following cycle,
  // and rises seen outside IDLE are dropped so a placement is never restarted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      gc_q          <= 1'b0;
      rise_q        <= 1'b0;
      cand          <= 8'hC5;
      tries         <= '0;
      scan          <= 1'b0;
      scanned       <= '0;
      idx           <= '0;
      apple_x_r     <= 4'hC;
      apple_y_r     <= 4'h5;
      apple_valid_r <= 1'b1;
      busy_r        <= 1'b0;
      place_done_r  <= 1'b0;
      board_full_r  <= 1'b0;
    end else begin
      gc_q         <= bus.goodColl;
      rise_q       <= rise && (state == IDLE);
      place_done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_q) begin
            state         <= SAMPLE;
            busy_r        <= 1'b1;
            apple_valid_r <= 1'b0;
            tries         <= '0;
            scan          <= 1'b0;
          end
        end
        SAMPLE: begin
          cand  <= {bus.randX, bus.randY};
          tries <= tries + TW'(1);
          idx   <= '0;
          state <= CHECK;
        end
        CHECK: begin
          if (hit) begin
            if (!scan) begin
              if (tries >= TW'(MAX_TRIES)) begin
                // Random draws exhausted: walk the board linearly from the last candidate
                scan    <= 1'b1;
                cand    <= cand + 8'd1;
                scanned <= 9'd1;
                idx     <= '0;
              end else begin
                state <= SAMPLE;
              end
            end else if (scanned == 9'd256) begin
              board_full_r <= 1'b1;
              busy_r       <= 1'b0;
              state        <= IDLE;
            end else begin
              cand    <= cand + 8'd1;
              scanned <= scanned + 9'd1;
              idx     <= '0;
            end
          end else if (last) begin
            state <= COMMIT;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        COMMIT: begin
          apple_x_r     <= cand[7:4];
          apple_y_r     <= cand[3:0];
          apple_valid_r <= 1'b1;
          place_done_r  <= 1'b1;
          board_full_r  <= 1'b0;
          busy_r        <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apple_placement_ctrl.sv
// tb/tb_apple_placement_ctrl.sv - scoreboard bench for apple_placement_ctrl
module tb_apple_placement_ctrl;
  localparam int ML = 256;
  localparam int LWB = 9;

  typedef struct {
    logic [7:0] apple;
    int         edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   n_exp = 0;
  exp_t exp_q[$];
  logic [7:0] seg_tb [ML];

  apple_placement_if #(.MAX_LENGTH(ML), .LW(LWB)) bus ();

  apple_placement_ctrl #(.MAX_LENGTH(ML), .MAX_TRIES(4), .LW(LWB)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every place_done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!reset && bus.place_done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_apple", {24'd0, bus.apple_x, bus.apple_y}, {24'd0, e.apple});
        chk("done_edge", cyc, e.edge_no);
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic load_body(input int len);
    bus.body = '0;
    for (int i = 0; i < ML; i++) bus.body[8*i +: 8] = seg_tb[i];
    bus.length = LWB'(len);
  endtask

  task automatic set_rand(input logic [7:0] r);
    bus.randX = r[7:4];
    bus.randY = r[3:0];
  endtask

  // Raise goodColl now (at a negedge); returns the edge index t at which the rise is sampled
  task automatic trigger(output int t);
    bus.goodColl = 1'b1;
    t = cyc + 1;
  endtask

  task automatic expect_done(input logic [7:0] a, input int edge_no);
    exp_t e;
    e.apple = a;
    e.edge_no = edge_no;
    exp_q.push_back(e);
    n_exp++;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < max_cycles) begin
      step(1);
      n++;
    end
    step(1);
    chk("drain_pending", exp_q.size() + int'(bus.busy), 0);
  endtask

  initial begin
    int t;
    int n;
    bus.goodColl = 1'b0;
    set_rand(8'h00);
    for (int i = 0; i < ML; i++) seg_tb[i] = 8'h00;
    load_body(0);

    // Reset state
    step(2);
    chk("rst_apple_x", bus.apple_x, 4'hC);
    chk("rst_apple_y", bus.apple_y, 4'h5);
    chk("rst_valid", bus.apple_valid, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_full", bus.board_full, 1'b0);
    reset = 1'b0;
    step(2);

    // First-draw success, length 3
    seg_tb[0] = 8'h11; seg_tb[1] = 8'h22; seg_tb[2] = 8'h33;
    load_body(3);
    set_rand(8'h47);
    trigger(t);
    expect_done(8'h47, t + 6);
    step(1);
    chk("t1_busy_t0", bus.busy, 1'b0);
    step(1);
    chk("t1_busy_t1", bus.busy, 1'b1);
    chk("t1_valid_t1", bus.apple_valid, 1'b0);
    step(4);
    chk("t1_busy_t5", bus.busy, 1'b1);
    chk("t1_done_t5", bus.place_done, 1'b0);
    step(1);
    chk("t1_busy_t6", bus.busy, 1'b0);
    chk("t1_valid_t6", bus.apple_valid, 1'b1);
    bus.goodColl = 1'b0;
    drain(50);

    // One retry: first draw hits body[1], second draw is free
    seg_tb[0] = 8'h50; seg_tb[1] = 8'h61;
    load_body(2);
    set_rand(8'h61);
    trigger(t);
    expect_done(8'h9A, t + 8);
    step(3);
    set_rand(8'h9A);
    bus.goodColl = 1'b0;
    drain(50);

    // Four rejected draws then linear scan
    seg_tb[0] = 8'h10;
    load_body(1);
    set_rand(8'h10);
    trigger(t);
    expect_done(8'h11, t + 11);
    step(2);
    bus.goodColl = 1'b0;
    drain(50);

    // goodColl held high for 20 cycles -> exactly one placement
    seg_tb[0] = 8'h11; seg_tb[1] = 8'h22; seg_tb[2] = 8'h33;
    load_body(3);
    set_rand(8'h47);
    trigger(t);
    expect_done(8'h47, t + 6);
    step(20);
    bus.goodColl = 1'b0;
    drain(50);

    // Re-pulse while busy is ignored
    for (int i = 0; i < 20; i++) seg_tb[i] = 8'h80 + 8'(i);
    load_body(20);
    set_rand(8'h05);
    trigger(t);
    expect_done(8'h05, t + 23);
    step(2);
    bus.goodColl = 1'b0;
    step(3);
    bus.goodColl = 1'b1;
    step(2);
    bus.goodColl = 1'b0;
    drain(100);

    // Reset mid-CHECK aborts immediately, no place_done
    set_rand(8'h3C);
    trigger(t);
    step(6);
    chk("mid_busy", bus.busy, 1'b1);
    bus.goodColl = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_apple", {bus.apple_x, bus.apple_y}, 8'hC5);
    chk("abort_valid", bus.apple_valid, 1'b1);
    chk("abort_busy", bus.busy, 1'b0);
    step(2);
    reset = 1'b0;
    step(40);

    // Full board: every cell occupied, body[i] = i
    for (int i = 0; i < ML; i++) seg_tb[i] = 8'(i);
    load_body(256);
    set_rand(8'h37);
    trigger(t);
    step(2);
    bus.goodColl = 1'b0;
    n = 0;
    while (bus.busy && n < 70000) begin
      step(1);
      n++;
    end
    chk("full_edge", cyc, t + 33125);
    chk("full_flag", bus.board_full, 1'b1);
    chk("full_valid", bus.apple_valid, 1'b0);
    chk("full_busy", bus.busy, 1'b0);
    step(3);
    chk("full_sticky", bus.board_full, 1'b1);

    // Next successful commit clears board_full; empty body takes one CHECK cycle
    load_body(0);
    set_rand(8'hAB);
    trigger(t);
    expect_done(8'hAB, t + 4);
    step(2);
    bus.goodColl = 1'b0;
    drain(50);
    chk("full_cleared", bus.board_full, 1'b0);
    chk("done_count", n_done, n_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apple_placement_ctrl.md
# apple_placement_ctrl

Sequencing controller that places a new apple after the snake eats the current one. On a rising edge of `goodColl` it draws candidate coordinates from the random source. It checks each candidate serially against every occupied body segment, retries on overlap, and falls back to a deterministic linear scan after `MAX_TRIES` failed draws. It then commits the coordinate to the registered apple position consumed by the display and collision logic.

## Interface
- `MAX_LENGTH`, default 16: number of body segment slots.
- `MAX_TRIES`, default 4: random draws attempted before switching to linear scan (≥1).
- `LW`, default `$clog2(MAX_LENGTH+1)`: width of `length`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `goodColl`  in  1  head-on-apple indication; already synchronous to `clk`; level, may stay high several cycles.
- `randX`  in  4  random X source, new value every cycle.
- `randY`  in  4  random Y source, new value every cycle.
- `body`  in  8*MAX_LENGTH  flattened segment list; segment i at `[8i+7:8i]`, format `{x,y}`.
- `length`  in  LW  number of valid segments (0..MAX_LENGTH); segments ≥ `length` ignored.
- `apple_x`  out  4  committed apple X.
- `apple_y`  out  4  committed apple Y.
- `apple_valid`  out  1  apple position valid and displayable.
- `busy`  out  1  placement in progress.
- `place_done`  out  1  one-cycle pulse on commit.
- `board_full`  out  1  sticky; no free cell found.

## Operation
- Internal `gc_q` register tracks the previous `goodColl`. `rise = goodColl & ~gc_q`. `gc_q` updates every cycle in all states.
- States: IDLE, SAMPLE, CHECK, COMMIT.
- IDLE: `busy`=0. On `rise` → SAMPLE; `apple_valid`←0, `tries`←0, `scan`←0. Without `rise`, remain in IDLE.
- SAMPLE: `cand`←`{randX,randY}`, `tries`←`tries`+1, `idx`←0 → CHECK.
- CHECK: one compare per cycle, `cand` vs `body[idx]`.
  - Match, `scan`=0, `tries`<`MAX_TRIES` → SAMPLE.
  - Match, `scan`=0, `tries`=`MAX_TRIES` → set `scan`←1, `cand`←`cand`+1 (8-bit wrap, 0xFF→0x00), `scanned`←1, `idx`←0, stay CHECK.
  - Match, `scan`=1: if `scanned`=256 → `board_full`←1 → IDLE with `apple_valid`=0. Otherwise `cand`←`cand`+1, `scanned`←`scanned`+1, `idx`←0, stay CHECK.
  - No match and `idx`=`length`-1 → COMMIT. Otherwise `idx`←`idx`+1.
  - If `length`=0, CHECK spends one cycle and → COMMIT.
- COMMIT: `{apple_x,apple_y}`←`cand`, `apple_valid`←1, `place_done`=1 for this cycle → IDLE.
- `busy`=1 in SAMPLE, CHECK and COMMIT.
- `scanned` is 9 bits wide. `tries` is `$clog2(MAX_TRIES+1)` bits wide.
- `goodColl` rises while `busy` are ignored; placement is never restarted.
- `board_full` clears only on reset, or on the next successful COMMIT.
- `body` and `length` are sampled live each CHECK cycle. Upstream holds them stable while `busy`=1.

## Timing
- Reset values:
  - `apple_x`=0xC, `apple_y`=0x5, `apple_valid`=1.
  - `busy`=0, `place_done`=0, `board_full`=0.
  - State IDLE, `gc_q`=0.
- Reset asserted mid-placement aborts immediately to the reset values; no `place_done` is issued.
- `rise` is sampled at edge t: `apple_valid`=0 and `busy`=1 from t+1.
- First-draw success with `length`=L: `place_done` and new coordinates appear at edge t+3+max(L,1). `apple_valid`=1 from that edge.
- Each failed draw costs 1 SAMPLE cycle plus (k+1) CHECK cycles, where k is the index of the matching segment.
- Worst case (full board) is bounded by MAX_TRIES·(L+1) + 256·L + 2 cycles.

## Test plan
- Reset → `apple_x`=0xC, `apple_y`=0x5, `apple_valid`=1, `busy`=0, `board_full`=0.
- `length`=3, body {0x11,0x22,0x33}, rand=0x47, `goodColl` 0→1 at edge t → `apple`=0x47, `place_done` pulses at t+6, `busy` high t+1..t+6.
- `length`=2, body {0x50,0x61}, rand=0x61 for the first draw then 0x9A → retry once, then commit 0x9A; `place_done` at t+8.
- `MAX_TRIES`=4, rand fixed 0x10, body[0]=0x10, `length`=1 → four rejected draws, then scan commits 0x11.
- `length`=MAX_LENGTH with `MAX_LENGTH`=256, all cells covered → `board_full`=1, `apple_valid`=0, return to IDLE, no `place_done`.
- `goodColl` held high 20 cycles, and pulsed again while `busy` → exactly one placement. Reset asserted mid-CHECK → outputs return to reset values on the same edge.
